axil_master_bridge: RTL and testbench



---
 rtl/axil_master_bridge.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_bridge.sv
// axil_master_bridge
//   AXI4-Lite initiator. Accepts one read or write on a simple request
//   port and issues it on the m_axi_* port. One transaction at a time;
//   the result is returned on a registered response port.
//
//   Optional feature macro: AXIL_MST_TIMEOUT_EN
//     When defined, a watchdog ends a stalled transaction after
//     TIMEOUT_CYCLES cycles with resp_err=1 and resp_timeout=1. The
//     outstanding AXI transaction is then drained in the DRAIN state.
//
//   Ports
//     aclk, areset              clock, synchronous active-high reset
//     req_valid/req_ready       request handshake
//     req_write                 1 = write, 0 = read
//     req_addr/wdata/wstrb      request payload
//     resp_valid/resp_ready     response handshake
//     resp_rdata                read data (0 for writes and timeouts)
//     resp_err                  BRESP/RRESP[1] or watchdog timeout
//     resp_timeout              response produced by the watchdog
//     m_axi_aw*/w*/b*/ar*/r*    AXI4-Lite master port
//
//   State        | meaning
//   IDLE         | waiting for a request, req_ready=1
//   WADDR        | AW and W valids presented, waiting for both handshakes
//   WRESP        | bready=1, waiting for B
//   RADDR        | arvalid=1, waiting for AR handshake
//   RDATA        | rready=1, waiting for R
//   RESP         | resp_valid=1, waiting for resp_ready
//   DRAIN        | (watchdog only) finish abandoned AXI transaction
module axil_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axil_master_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RESP
`ifdef AXIL_MST_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  // One pending flag per AXI channel. The valids/readies are driven
  // straight from these, so a valid stays up until its own handshake
  // even if the watchdog has already answered the requester.
  logic aw_pend, w_pend, b_pend, ar_pend, r_pend;

  logic accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic bready_int, rready_int;
  logic xact_left;
  logic timeout_hit;
  logic cap_b, cap_r, cap_to;
  logic unused_resp_bits;

  assign accept     = (state == IDLE) && req_valid;
  // B and R are only accepted once their address (and data) phase is done.
  assign bready_int = b_pend && !aw_pend && !w_pend;
  assign rready_int = r_pend && !ar_pend;

  assign aw_hs = aw_pend && m_axi_awready;
  assign w_hs  = w_pend && m_axi_wready;
  assign b_hs  = bready_int && m_axi_bvalid;
  assign ar_hs = ar_pend && m_axi_arready;
  assign r_hs  = rready_int && m_axi_rvalid;

  // Something on the AXI side is still outstanding after this edge.
  assign xact_left = (aw_pend && !aw_hs) || (w_pend && !w_hs) ||
                     (b_pend && !b_hs) || (ar_pend && !ar_hs) ||
                     (r_pend && !r_hs);

  assign unused_resp_bits = m_axi_bresp[0] ^ m_axi_rresp[0];

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             to_q;

  assign busy = (state == WADDR) || (state == WRESP) ||
                (state == RADDR) || (state == RDATA);
  // cnt is 0 in the first busy cycle, so the limit is reached in the
  // TIMEOUT_CYCLES-th busy cycle and RESP follows on the next edge.
  assign timeout_hit = busy && (cnt == CNT_LAST);

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      if (accept)    cnt <= '0;
      else if (busy) cnt <= cnt + 1'b1;

      if (cap_b || cap_r) to_q <= 1'b0;
      else if (cap_to)    to_q <= 1'b1;
    end
  end

  assign resp_timeout = to_q;
`else
  assign timeout_hit  = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_b     = 1'b0;
    cap_r     = 1'b0;
    cap_to    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = req_write ? WADDR : RADDR;
      end
      WADDR: begin
        if (timeout_hit) begin
          state_nxt = RESP;
          cap_to    = 1'b1;
        end else if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) begin
          state_nxt = WRESP;
        end
      end
      WRESP: begin
        // A response arriving on the timeout cycle is still honoured.
        if (b_hs) begin
          state_nxt = RESP;
          cap_b     = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = RESP;
          cap_to    = 1'b1;
        end
      end
      RADDR: begin
        if (timeout_hit) begin
          state_nxt = RESP;
          cap_to    = 1'b1;
        end else if (ar_hs) begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          state_nxt = RESP;
          cap_r     = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = RESP;
          cap_to    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
`ifdef AXIL_MST_TIMEOUT_EN
          state_nxt = xact_left ? DRAIN : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef AXIL_MST_TIMEOUT_EN
      DRAIN: begin
        if (!xact_left) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      b_pend  <= 1'b0;
      ar_pend <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_pend <= req_write;
        w_pend  <= req_write;
        b_pend  <= req_write;
        ar_pend <= !req_write;
        r_pend  <= !req_write;
      end else begin
        if (aw_hs) aw_pend <= 1'b0;
        if (w_hs)  w_pend  <= 1'b0;
        if (b_hs)  b_pend  <= 1'b0;
        if (ar_hs) ar_pend <= 1'b0;
        if (r_hs)  r_pend  <= 1'b0;
      end

      // Results that complete while draining are discarded: cap_* only
      // fire from the working states.
      if (cap_b) begin
        rdata_q <= '0;
        err_q   <= m_axi_bresp[1];
      end else if (cap_r) begin
        rdata_q <= m_axi_rdata;
        err_q   <= m_axi_rresp[1];
      end else if (cap_to) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = aw_pend;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = w_pend;
  assign m_axi_bready  = bready_int;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = ar_pend;
  assign m_axi_rready  = rready_int;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Testbench for axil_master_bridge: table of directed transactions against
// a cycle-scripted AXI-Lite slave, plus hand sequences for response
// back-pressure, mid-transaction reset and a hung read address channel.
module tb_axil_master_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, resp_timeout;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 aclk = ~aclk;

  axil_master_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // d_a: AW/AR ready delay, d_w: W ready delay, d_resp: B/R valid delay.
  // exp_lat: cycle (counted from the accepting edge = cycle 0) in which
  // resp_valid is first seen.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          d_a;
    int          d_w;
    int          d_resp;
    logic [1:0]  code;
    logic [31:0] rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic axi_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b10;
    m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b10; m_axi_rdata = 32'hFFFF_FFFF;
  endtask

  // Called at a negedge with aclk low; the request is accepted at the
  // following posedge (cycle 0).
  task automatic issue(input vec_t v);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.strb;
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
  endtask

  // Acts as the slave from cycle 1 onward until resp_valid is seen.
  // Returns at the negedge of the response cycle.
  task automatic service(input vec_t v, input string tag, output int lat);
    int aw_n, w_n, b_n, ar_n, r_n, viol;
    int aw_c, w_c, ar_c, last_c;
    logic p_aw, p_w, p_ar;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; viol = 0;
    aw_c = -1; w_c = -1; ar_c = -1; lat = -1;
    p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge aclk);
      if (p_aw && !m_axi_awvalid) viol++;
      if (p_w  && !m_axi_wvalid)  viol++;
      if (p_ar && !m_axi_arvalid) viol++;
      if (aw_n > 0 && m_axi_awvalid) viol++;
      if (w_n  > 0 && m_axi_wvalid)  viol++;
      if (ar_n > 0 && m_axi_arvalid) viol++;
      if (resp_valid) begin
        lat = c;
        axi_idle();
      end else begin
        last_c = (aw_c > w_c) ? aw_c : w_c;
        m_axi_awready = v.wr  && (c >= 1 + v.d_a);
        m_axi_wready  = v.wr  && (c >= 1 + v.d_w);
        m_axi_arready = !v.wr && (c >= 1 + v.d_a);
        m_axi_bvalid  = v.wr && aw_c > 0 && w_c > 0 && b_n == 0 && (c >= last_c + 1 + v.d_resp);
        m_axi_bresp   = m_axi_bvalid ? v.code : 2'b10;
        m_axi_rvalid  = !v.wr && ar_c > 0 && r_n == 0 && (c >= ar_c + 1 + v.d_resp);
        m_axi_rresp   = m_axi_rvalid ? v.code : 2'b10;
        m_axi_rdata   = m_axi_rvalid ? v.rd : 32'hFFFF_FFFF;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_n++; aw_c = c;
          chk({tag, "_awaddr"}, m_axi_awaddr, v.addr);
          chk({tag, "_awprot"}, {29'd0, m_axi_awprot}, 32'd0);
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_n++; w_c = c;
          chk({tag, "_wdata"}, m_axi_wdata, v.wdata);
          chk({tag, "_wstrb"}, {28'd0, m_axi_wstrb}, {28'd0, v.strb});
        end
        if (m_axi_arvalid && m_axi_arready) begin
          ar_n++; ar_c = c;
          chk({tag, "_araddr"}, m_axi_araddr, v.addr);
          chk({tag, "_arprot"}, {29'd0, m_axi_arprot}, 32'd0);
        end
        if (m_axi_bvalid && m_axi_bready) b_n++;
        if (m_axi_rvalid && m_axi_rready) r_n++;
        p_aw = m_axi_awvalid && !m_axi_awready;
        p_w  = m_axi_wvalid  && !m_axi_wready;
        p_ar = m_axi_arvalid && !m_axi_arready;
      end
    end
    chk({tag, "_lat"}, lat, v.exp_lat);
    chk({tag, "_viol"}, viol, 0);
    if (v.wr) begin
      chk({tag, "_hs_aw_w_b_ar"}, {aw_n[7:0], w_n[7:0], b_n[7:0], ar_n[7:0]}, 32'h0101_0100);
      chk({tag, "_aw_cycle"}, aw_c, 1 + v.d_a);
      chk({tag, "_w_cycle"}, w_c, 1 + v.d_w);
    end else begin
      chk({tag, "_hs_ar_r_aw_w"}, {ar_n[7:0], r_n[7:0], aw_n[7:0], w_n[7:0]}, 32'h0101_0000);
      chk({tag, "_ar_cycle"}, ar_c, 1 + v.d_a);
    end
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    @(negedge aclk);
    resp_ready = 1'b0;
    chk({tag, "_resp_valid_after"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_resp(input vec_t v, input string tag);
    chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    chk({tag, "_timeout"}, {31'd0, resp_timeout}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, first, ar_c, r_c, arv_drop, rr_bad;
    logic [31:0] t_rdata;
    logic t_err, t_to;
    vec_t v;

    //          wr    addr          wdata         strb  da dw dr code   rd             exp_rdata      err   lat
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,         32'h0,         1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0, 3};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 3, 0, 0, 2'b00, 32'h0,         32'h0,         1'b0, 6};
    vecs[3] = '{1'b1, 32'h0000_0024, 32'hCAFE_0001, 4'hC, 0, 3, 0, 2'b00, 32'h0,         32'h0,         1'b0, 6};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 2'b10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 3};
    vecs[5] = '{1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b11, 32'h0,         32'h0,         1'b1, 3};
    vecs[6] = '{1'b1, 32'h0000_0034, 32'h1111_2222, 4'h0, 0, 0, 2, 2'b01, 32'h0,         32'h0,         1'b0, 5};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2, 0, 1, 2'b01, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 6};
    vecs[8] = '{1'b1, 32'h0000_0040, 32'h8765_4321, 4'h9, 2, 2, 0, 2'b00, 32'h0,         32'h0,         1'b0, 5};

    areset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    axi_idle();
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                       m_axi_arvalid, m_axi_rready, resp_valid}, 32'd0);
    chk("rst_resp_flags", {30'd0, resp_err, resp_timeout}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    chk("rst_araddr", m_axi_araddr, 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_wstrb_prot", {22'd0, m_axi_wstrb, m_axi_awprot, m_axi_arprot}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      @(negedge aclk);
      chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
      issue(vecs[i]);
      service(vecs[i], $sformatf("v%0d", i), lat);
      check_resp(vecs[i], $sformatf("v%0d", i));
      consume($sformatf("v%0d", i));
    end

    // Response held for 5 cycles while a new request waits.
    @(negedge aclk);
    issue(vecs[1]);
    service(vecs[1], "ovl_rd", lat);
    check_resp(vecs[1], "ovl_rd");
    v = vecs[0];
    v.addr = 32'h0000_0050;
    v.wdata = 32'h0102_0304;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.strb;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk($sformatf("ovl_hold%0d_state", k),
          {28'd0, resp_valid, req_ready, m_axi_awvalid, m_axi_arvalid}, 32'h8);
      chk($sformatf("ovl_hold%0d_rdata", k), resp_rdata, 32'h1234_5678);
    end
    resp_ready = 1'b1;
    @(negedge aclk);
    resp_ready = 1'b0;
    chk("ovl_back_idle", {30'd0, req_ready, m_axi_awvalid}, 32'h2);
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
    service(v, "ovl_wr", lat);
    check_resp(v, "ovl_wr");
    consume("ovl_wr");

    // Reset in the middle of a write with the slave stalling.
    @(negedge aclk);
    issue(vecs[2]);
    @(negedge aclk);
    chk("mrst_aw_pending", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("mrst_outputs", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         req_ready, resp_valid}, 32'h2);
    chk("mrst_awaddr", m_axi_awaddr, 32'd0);
    @(negedge aclk);
    issue(vecs[0]);
    service(vecs[0], "post_rst", lat);
    check_resp(vecs[0], "post_rst");
    consume("post_rst");

    // Read whose slave holds arready low for 40 cycles.
    @(negedge aclk);
    v = vecs[1];
    v.addr = 32'h0000_0060;
    issue(v);
    first = -1; ar_c = -1; r_c = -1; arv_drop = 0; rr_bad = 0;
    t_rdata = '0; t_err = 1'b0; t_to = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge aclk);
      m_axi_arready = (c == 41);
      m_axi_rvalid  = (c == 42);
      m_axi_rresp   = 2'b00;
      m_axi_rdata   = 32'h7777_7777;
      if (resp_valid && first < 0) begin
        first = c; t_rdata = resp_rdata; t_err = resp_err; t_to = resp_timeout;
        resp_ready = 1'b1;
      end else begin
        resp_ready = 1'b0;
      end
      if (c <= 40 && !m_axi_arvalid) arv_drop++;
      if (m_axi_arvalid && m_axi_arready) ar_c = c;
      if (m_axi_rvalid && m_axi_rready) r_c = c;
`ifdef AXIL_MST_TIMEOUT_EN
      if (c >= 18 && c <= 42 && (req_ready || resp_valid)) rr_bad++;
      if (c == 43) begin
        chk("to_req_ready_after_drain", {31'd0, req_ready}, 32'd1);
        chk("to_rdata_discarded", resp_rdata, 32'd0);
      end
`endif
    end
    axi_idle();
    chk("hang_arvalid_held", arv_drop, 0);
    chk("hang_ar_cycle", ar_c, 41);
    chk("hang_r_cycle", r_c, 42);
`ifdef AXIL_MST_TIMEOUT_EN
    chk("to_resp_cycle", first, 17);
    chk("to_resp_flags", {30'd0, t_err, t_to}, 32'h3);
    chk("to_resp_rdata", t_rdata, 32'd0);
    chk("to_drain_busy", rr_bad, 0);
`else
    chk("hang_resp_cycle", first, 43);
    chk("hang_resp_flags", {30'd0, t_err, t_to}, 32'd0);
    chk("hang_resp_rdata", t_rdata, 32'h7777_7777);
    chk("hang_unused_cnt", rr_bad, 0);
`endif
    @(negedge aclk);
    chk("end_idle", {30'd0, req_ready, resp_valid}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
